ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
Initiator-side controller that drives a 16x8 dual-port RAM as a synchronous FIFO. It accepts push/pop requests from a client and generates the RAM write port (wr_addr, wr_data, we) and read port (rd_addr, re). It captures the RAM's d_out as FIFO read data and tracks occupancy with full/empty/count flags.

Parameters:
width, 8, data word width; must match the RAM data width
depth, 16, number of RAM locations; equals 2**addr
addr, 4, RAM address width

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of pointers and occupancy
push  input  1  write request
push_data  input  width  data to enqueue
pop  input  1  read request
full  output  1  FIFO holds depth words
empty  output  1  FIFO holds 0 words
count  output  addr+1  current occupancy, 0..depth
pop_data  output  width  dequeued word, valid when pop_valid=1
pop_valid  output  1  pop_data valid this cycle
overflow  output  1  one-cycle pulse: push rejected because full
underflow  output  1  one-cycle pulse: pop rejected because empty
ram_wr_addr  output  addr  RAM write address
ram_wr_data  output  width  RAM write data
ram_we  output  1  RAM write enable
ram_rd_addr  output  addr  RAM read address
ram_re  output  1  RAM read enable
ram_d_out  input  width  RAM read data; valid one clock after ram_re sampled high

Behaviour:
- Reset (rst high, asynchronous): wr_ptr=0, rd_ptr=0, count=0, full=0, empty=1, pop_valid=0, pop_data=0, overflow=0, underflow=0. ram_we and ram_re are forced 0 while rst is high. Reset asserted mid-operation discards all contents immediately.
- Accept rules: push_acc = push & ~full & ~flush. pop_acc = pop & ~empty & ~flush. full and empty are decoded from registered count (full = count==depth, empty = count==0).
- Write path (combinational from request): ram_we=push_acc, ram_wr_addr=wr_ptr, ram_wr_data=push_data. The RAM stores the word at the same posedge. wr_ptr increments on push_acc and wraps from depth-1 to 0.
- Read path: ram_re=pop_acc, ram_rd_addr=rd_ptr. rd_ptr increments on pop_acc and wraps from depth-1 to 0. pop_valid is registered pop_acc, so it is high exactly one cycle after an accepted pop. pop_data follows ram_d_out in that cycle.
- Read latency is 1 clock, from the pop-accepted edge to pop_valid/pop_data. Back-to-back pops give one word per cycle.
- Count: +1 on push_acc only, -1 on pop_acc only, unchanged if both or neither.
- Simultaneous push and pop:
  - When empty: push accepted, pop rejected with an underflow pulse. There is no fall-through.
  - When full: pop accepted, push rejected with an overflow pulse.
  - Otherwise: both accepted, and wr_ptr≠rd_ptr, so there is never a same-address RAM collision.
- overflow and underflow are registered: high for the one cycle after the rejected request, then 0.
- flush: on a posedge with flush=1, pointers and count go to 0 and pop_valid goes to 0 next cycle. push and pop in that cycle are ignored and raise no overflow/underflow. The RAM contents are not cleared.
- Pointer wrap: after depth pushes and depth pops, both pointers return to 0. Ordering is preserved across the wrap.

Test Plan:
- Reset then push 0xAA,0xBB,0xCC on consecutive cycles -> ram_we=1 with ram_wr_addr 0,1,2; count=3; empty=0; full=0.
- Pop three times back-to-back -> ram_rd_addr 0,1,2; pop_valid high for 3 cycles starting one clock after the first pop; pop_data 0xAA,0xBB,0xCC; empty=1; count=0.
- Push 16 words 0x00..0x0F, then push 0x55 -> full=1, count=16, ram_we=0 for 0x55, overflow pulse one cycle. Pop all 16 -> data 0x00..0x0F in order.
- Pop on empty FIFO, and push+pop together on empty -> underflow pulse both times, no pop_valid. The push is accepted and count=1.
- Fill to 15, then 20 cycles of simultaneous push+pop -> count stays 15, pointers wrap past 15→0, popped data matches push order, no overflow/underflow.
- Assert flush with count=5 (push asserted too) -> next cycle count=0, empty=1, no write. Assert rst mid-burst -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: drives a dual-port RAM as a synchronous FIFO.
// Tracks pointers and occupancy; pop data is the RAM output one clock after an accepted pop.
module ram_fifo_ctrl #(
    parameter int width = 8,
    parameter int depth = 16,
    parameter int addr  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [addr:0]    count,
    output logic [width-1:0] pop_data,
    output logic             pop_valid,
    output logic             overflow,
    output logic             underflow,
    output logic [addr-1:0]  ram_wr_addr,
    output logic [width-1:0] ram_wr_data,
    output logic             ram_we,
    output logic [addr-1:0]  ram_rd_addr,
    output logic             ram_re,
    input  logic [width-1:0] ram_d_out
);
    logic [addr-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [addr:0]   count_q, count_d;
    logic            pop_valid_q, pop_valid_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;
    logic            push_acc, pop_acc;

    always_comb begin
        full        = count_q == (addr+1)'(depth);
        empty       = count_q == '0;
        push_acc    = push & ~full & ~flush;
        pop_acc     = pop & ~empty & ~flush;
        // Pointers wrap naturally because depth is a power of two.
        wr_ptr_d    = flush ? '0 : wr_ptr_q + addr'(push_acc);
        rd_ptr_d    = flush ? '0 : rd_ptr_q + addr'(pop_acc);
        count_d     = flush ? '0 : count_q + (addr+1)'(push_acc) - (addr+1)'(pop_acc);
        pop_valid_d = pop_acc;
        overflow_d  = push & full & ~flush;
        underflow_d = pop & empty & ~flush;
        count       = count_q;
        pop_valid   = pop_valid_q;
        pop_data    = pop_valid_q ? ram_d_out : '0;
        overflow    = overflow_q;
        underflow   = underflow_q;
        // Enables are also masked by rst so no RAM access leaks out during reset.
        ram_we      = push_acc & ~rst;
        ram_wr_addr = wr_ptr_q;
        ram_wr_data = push_data;
        ram_re      = pop_acc & ~rst;
        ram_rd_addr = rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed stimulus with a reference FIFO model and a pop-data scoreboard.
module tb_ram_fifo_ctrl;
    logic       clk = 0, rst = 1, flush = 0, push = 0, pop = 0;
    logic [7:0] push_data = 0;
    logic       full, empty, pop_valid, overflow, underflow, ram_we, ram_re;
    logic [4:0] count;
    logic [7:0] pop_data, ram_wr_data, ram_d_out = 0;
    logic [3:0] ram_wr_addr, ram_rd_addr;
    logic [7:0] mem [16];

    int checks = 0, errors = 0;
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic [3:0] wptr = 0, rptr = 0;

    ram_fifo_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush), .push(push), .push_data(push_data), .pop(pop),
        .full(full), .empty(empty), .count(count), .pop_data(pop_data), .pop_valid(pop_valid),
        .overflow(overflow), .underflow(underflow), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .ram_we(ram_we), .ram_rd_addr(ram_rd_addr), .ram_re(ram_re),
        .ram_d_out(ram_d_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_re) ram_d_out <= mem[ram_rd_addr];
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask

    // Monitor: every presented pop word must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && pop_valid) begin
            if (exp_q.size() == 0) chk("unexpected_pop_valid", 1, 0);
            else chk("pop_data", pop_data, exp_q.pop_front());
        end
    end

    task automatic step(input bit p, input logic [7:0] d, input bit q, input bit f);
        bit pa, qa, fb, eb;
        push = p; push_data = d; pop = q; flush = f;
        fb = mq.size() == 16;
        eb = mq.size() == 0;
        pa = p && !fb && !f;
        qa = q && !eb && !f;
        @(negedge clk);
        chk("count", count, mq.size());
        chk("full", full, fb);
        chk("empty", empty, eb);
        chk("ram_we", ram_we, pa);
        chk("ram_re", ram_re, qa);
        if (pa) begin
            chk("ram_wr_addr", ram_wr_addr, wptr);
            chk("ram_wr_data", ram_wr_data, d);
        end
        if (qa) chk("ram_rd_addr", ram_rd_addr, rptr);
        if (qa) begin exp_q.push_back(mq.pop_front()); rptr++; end
        if (pa) begin mq.push_back(d); wptr++; end
        if (f) begin mq.delete(); wptr = 0; rptr = 0; end
        @(posedge clk); #1;
        chk("pop_valid", pop_valid, qa);
        chk("overflow", overflow, p && fb && !f);
        chk("underflow", underflow, q && eb && !f);
    endtask

    initial begin
        #2;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_pop_valid", pop_valid, 0);
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        step(1, 8'hAA, 0, 0); step(1, 8'hBB, 0, 0); step(1, 8'hCC, 0, 0);
        step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
        step(1, 8'h55, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(1, 8'h77, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 15; i++) step(1, 8'h80 + 8'(i), 0, 0);
        for (int i = 0; i < 20; i++) step(1, 8'hA0 + 8'(i), 1, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 8'h30 + 8'(i), 0, 0);
        step(1, 8'h99, 1, 1);
        step(1, 8'h3F, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 8'h11 + 8'(i), 0, 0);
        step(0, 0, 1, 0);
        push = 1; pop = 1; #1;
        rst = 1; #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        chk("arst_pop_valid", pop_valid, 0);
        chk("arst_pop_data", pop_data, 0);
        chk("arst_we", ram_we, 0);
        chk("arst_re", ram_re, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_underflow", underflow, 0);
        exp_q.delete(); mq.delete(); wptr = 0; rptr = 0;
        push = 0; pop = 0;
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        step(1, 8'h5A, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
